sync_fifo_drain: RTL and testbench

SYNC_FIFO_DRAIN -- requirements
Module: sync_fifo_drain

---
 rtl/sync_fifo_drain.sv | 166 ++++++++++++++++
 tb/tb_sync_fifo_drain.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_drain.sv
// sync_fifo_drain: pulls bursts of words from an upstream FIFO into a
// 2-entry output buffer and presents them on a valid/ready interface.
// A burst starts once BURST_LEN words are available, or earlier on a
// flush request.
// Optional feature: define SYNC_FIFO_DRAIN_PARITY_EN to add out_parity,
// the XOR of out_data.
module sync_fifo_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 9,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [CNT_WIDTH-1:0]  fifo_fcounter,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_enable,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic [15:0]           word_count
`ifdef SYNC_FIFO_DRAIN_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    localparam logic [CNT_WIDTH-1:0] BURST_CNT  = CNT_WIDTH'(BURST_LEN);
    localparam logic [3:0]           BURST_INIT = 4'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_t;

    state_t                  state;
    logic [3:0]              burst_left;
    logic                    pending;     // read issued last cycle, data on fifo_rdata now
    logic [1:0]              occ;         // output buffer occupancy
    logic [DATA_WIDTH-1:0]   slot1;       // second buffer entry; out_data is the head
    logic                    pop;
    logic                    push;
    logic                    start_full;
    logic                    start_flush;
    logic [2:0]              committed;

    assign pop         = out_valid && out_ready;
    assign push        = pending;
    assign out_valid   = (occ != 2'd0);
    assign start_full  = (fifo_fcounter >= BURST_CNT);
    assign start_flush = flush && !fifo_empty;

    // Slots that will be in use after this edge: a word leaving this cycle
    // frees its slot, which keeps reads back-to-back at full throughput.
    assign committed = {1'b0, occ} + {2'b0, pending} - {2'b0, pop};

    // The pop request is gated combinationally by fifo_empty so that a flag
    // rising mid-burst can never cause an underflow read.
    assign fifo_r_enable = (state == BURST) && (burst_left != 4'd0) &&
                           !fifo_empty && (committed < 3'd2);

`ifdef SYNC_FIFO_DRAIN_PARITY_EN
    assign out_parity = ^out_data;
`endif

    // Burst control FSM: state, remaining reads and the busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            burst_left <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_full) begin
                        state      <= BURST;
                        burst_left <= BURST_INIT;
                        busy       <= 1'b1;
                    end else if (start_flush) begin
                        // fewer than BURST_LEN words here, so the count fits
                        state      <= BURST;
                        burst_left <= 4'(fifo_fcounter);
                        busy       <= 1'b1;
                    end
                end
                BURST: begin
                    if (burst_left == 4'd0 || fifo_empty) begin
                        state      <= DRAIN;
                        burst_left <= '0;
                    end else if (fifo_r_enable) begin
                        burst_left <= burst_left - 4'd1;
                    end
                end
                DRAIN: begin
                    if (occ == 2'd0 && !pending) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    burst_left <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Track the read whose data arrives on fifo_rdata next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else begin
            pending <= fifo_r_enable;
        end
    end

    // Two-entry output buffer in FIFO order; out_data is the head entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ      <= '0;
            out_data <= '0;
            slot1    <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        out_data <= fifo_rdata;
                    end else begin
                        slot1 <= fifo_rdata;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) begin
                        out_data <= slot1;
                    end
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        out_data <= fifo_rdata;
                    end else begin
                        out_data <= slot1;
                        slot1    <= fifo_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Count words accepted by the consumer, wrapping at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count <= '0;
        end else if (pop) begin
            word_count <= word_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_sync_fifo_drain.sv
// Randomized self-checking bench for sync_fifo_drain. The upstream FIFO and
// the expected output stream are modelled with queues; burst rules are
// checked per burst episode from the word counts seen at entry.
module tb_sync_fifo_drain;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [8:0]  fifo_fcounter = '0;
    logic [7:0]  fifo_rdata = '0;
    logic        fifo_r_enable;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        busy;
    logic [15:0] word_count;
`ifdef SYNC_FIFO_DRAIN_PARITY_EN
    logic        out_parity;
`endif

    sync_fifo_drain #(
        .DATA_WIDTH(8),
        .CNT_WIDTH (9),
        .BURST_LEN (BL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_fcounter(fifo_fcounter),
        .fifo_rdata   (fifo_rdata),
        .fifo_r_enable(fifo_r_enable),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .word_count   (word_count)
`ifdef SYNC_FIFO_DRAIN_PARITY_EN
        ,
        .out_parity   (out_parity)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] fq[$];      // upstream FIFO contents
    logic [7:0] exp_q[$];   // words read and not yet accepted, in order
    logic [15:0] wc = '0;

    int   cyc = 0;
    int   n_rd, n_acc, first_rd, last_rd, first_acc, last_acc;
    logic busy_seen;

    logic hist = 1'b0, prev_busy = 1'b0, prev_trig = 1'b0;
    logic prev_v = 1'b0, prev_acc = 1'b0, ep_exact = 1'b0;
    logic [7:0] prev_d = '0;
    int   prev_fc = 0, ep_fc = 0, ep_reads = 0;
    logic rd_s, acc_s;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic sync_flags();
        fifo_empty    = (fq.size() == 0);
        fifo_fcounter = 9'(fq.size());
    endtask

    task automatic clr_stats();
        n_rd = 0; n_acc = 0; first_rd = 0; last_rd = 0;
        first_acc = 0; last_acc = 0; busy_seen = 1'b0;
    endtask

    // One clock: sample/check at negedge, model FIFO pop after posedge.
    task automatic step();
        logic [7:0] w;
        @(negedge clk);
        rd_s  = fifo_r_enable;
        acc_s = out_valid && out_ready;
        if (rd_s) begin
            check_eq("rd_while_empty", 32'(fifo_empty), 32'd0);
            check_eq("rd_while_idle", 32'(busy), 32'd1);
        end
        check_eq("word_count", 32'(word_count), 32'(wc));
`ifdef SYNC_FIFO_DRAIN_PARITY_EN
        if (out_valid && exp_q.size() != 0)
            check_eq("parity", 32'(out_parity), 32'(^exp_q[0]));
`endif
        if (hist) begin
            if (prev_v && !prev_acc) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_data", 32'(out_data), 32'(prev_d));
            end
            if (!prev_busy)
                check_eq("start_rule", 32'(busy), 32'(prev_trig));
            if (prev_busy && !busy) begin
                if (ep_exact)
                    check_eq("burst_reads", 32'(ep_reads), 32'(min_i(BL, ep_fc)));
                check_eq("drained_at_idle", 32'(exp_q.size()), 32'd0);
            end
            if (!prev_busy && busy) begin
                ep_reads = 0;
                ep_fc    = prev_fc;
                ep_exact = 1'b1;
            end
        end
        if (rd_s) ep_reads++;
        if (acc_s) begin
            check_eq("out_has_word", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check_eq("out_order", 32'(out_data), 32'(w));
            end
            wc++;
        end
        if (rd_s) begin
            if (n_rd == 0) first_rd = cyc;
            last_rd = cyc;
            n_rd++;
        end
        if (acc_s) begin
            if (n_acc == 0) first_acc = cyc;
            last_acc = cyc;
            n_acc++;
        end
        if (busy) busy_seen = 1'b1;
        hist      = 1'b1;
        prev_busy = busy;
        prev_trig = (int'(fifo_fcounter) >= BL) || (flush && !fifo_empty);
        prev_fc   = int'(fifo_fcounter);
        prev_v    = out_valid;
        prev_acc  = acc_s;
        prev_d    = out_data;
        @(posedge clk);
        #1;
        if (rd_s) begin
            w = (fq.size() != 0) ? fq.pop_front() : 8'h00;
            exp_q.push_back(w);
            fifo_rdata = w;
        end else begin
            fifo_rdata = 8'($urandom);
        end
        cyc++;
        sync_flags();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        flush = 1'b0;
        fq.delete();
        exp_q.delete();
        wc = '0;
        hist = 1'b0;
        prev_busy = 1'b0;
        sync_flags();
        repeat (2) step();
        reset = 1'b1;
    endtask

    task automatic run_idle(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((busy || n < 3) && n < 300);
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int g;
        #2 reset = 1'b0;
        #1;
        check_eq("rst_r_enable", 32'(fifo_r_enable), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_word_count", 32'(word_count), 32'd0);
        apply_reset();

        // Full burst of 4 at full throughput.
        for (int i = 0; i < 4; i++) fq.push_back(8'(8'h11 + i));
        sync_flags();
        out_ready = 1'b1;
        clr_stats();
        run_idle("t030_idle");
        check_eq("t030_reads", 32'(n_rd), 32'd4);
        check_eq("t030_rd_consec", 32'(last_rd - first_rd), 32'd3);
        check_eq("t030_accepts", 32'(n_acc), 32'd4);
        check_eq("t030_acc_consec", 32'(last_acc - first_acc), 32'd3);
        check_eq("t030_latency", 32'(first_acc - first_rd), 32'd2);
        check_eq("t030_word_count", 32'(word_count), 32'd4);

        // Below threshold: nothing until flush.
        for (int i = 0; i < 3; i++) fq.push_back(8'(8'h31 + i));
        sync_flags();
        clr_stats();
        repeat (20) step();
        check_eq("t031_no_reads", 32'(n_rd), 32'd0);
        check_eq("t031_not_busy", 32'(busy_seen), 32'd0);
        flush = 1'b1;
        run_idle("t031_idle");
        flush = 1'b0;
        check_eq("t031_reads", 32'(n_rd), 32'd3);
        check_eq("t031_accepts", 32'(n_acc), 32'd3);

        // Backpressure: buffer fills after 2 reads.
        for (int i = 0; i < 4; i++) fq.push_back(8'(8'h21 + i));
        sync_flags();
        out_ready = 1'b0;
        clr_stats();
        repeat (10) step();
        check_eq("t032_reads_stalled", 32'(n_rd), 32'd2);
        check_eq("t032_valid", 32'(out_valid), 32'd1);
        check_eq("t032_head", 32'(out_data), 32'h21);
        out_ready = 1'b1;
        run_idle("t032_idle");
        check_eq("t032_reads", 32'(n_rd), 32'd4);
        check_eq("t032_accepts", 32'(n_acc), 32'd4);

        // Upstream empties after 2 reads of a 4-burst.
        for (int i = 0; i < 4; i++) fq.push_back(8'(8'h41 + i));
        sync_flags();
        clr_stats();
        g = 0;
        while (n_rd < 2 && g < 50) begin
            step();
            g++;
        end
        fq.delete();
        sync_flags();
        ep_exact = 1'b0;
        run_idle("t033_idle");
        check_eq("t033_reads", 32'(n_rd), 32'd2);
        check_eq("t033_accepts", 32'(n_acc), 32'd2);

        // Reset with a read in flight.
        for (int i = 0; i < 4; i++) fq.push_back(8'(8'h51 + i));
        sync_flags();
        clr_stats();
        g = 0;
        while (n_rd < 1 && g < 50) begin
            step();
            g++;
        end
        reset = 1'b0;
        #1;
        check_eq("t034_valid", 32'(out_valid), 32'd0);
        check_eq("t034_word_count", 32'(word_count), 32'd0);
        check_eq("t034_busy", 32'(busy), 32'd0);
        check_eq("t034_r_enable", 32'(fifo_r_enable), 32'd0);
        apply_reset();
        clr_stats();
        repeat (10) step();
        check_eq("t034_no_ghost", 32'(n_acc), 32'd0);
        check_eq("t034_idle", 32'(busy_seen), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            out_ready = (($urandom % 10) < 7);
            flush     = (($urandom % 16) == 0);
            if (!busy && fq.size() < 20 && ($urandom % 4) == 0) begin
                int k;
                k = int'($urandom_range(1, 3));
                for (int j = 0; j < k; j++) fq.push_back(8'($urandom));
                sync_flags();
            end
            step();
        end
        out_ready = 1'b1;
        flush = 1'b1;
        g = 0;
        while ((fq.size() != 0 || busy || exp_q.size() != 0) && g < 500) begin
            step();
            g++;
        end
        flush = 1'b0;
        check_eq("final_drain", 32'(fq.size() + exp_q.size()), 32'd0);
        check_eq("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
